key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//   Conditions the raw, bouncing, active-low DE-series pushbuttons (KEY) before
//   they reach the HEX-selector and other control logic. Each channel gets a
//   2-flop synchroniser and a debounce FSM.
//   Outputs per channel: a clean active-high held level, plus 1-cycle press and
//   release pulses. Downstream load enables use Press instead of the raw KEY level.
// PARAMETERS
//   N_KEYS           2        number of pushbutton channels (>=1)
//   DEBOUNCE_CYCLES  500000   cycles a new level must hold (10 ms at 50 MHz), >=1
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)   counter width (derived, localparam)
// PORTS
//   CLOCK_50  in   1       system clock, all logic on posedge
//   Reset     in   1       synchronous, active-high reset
//   KEY       in   N_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous
//   Held      out  N_KEYS  debounced level, active-high (1 = pressed)
//   Press     out  N_KEYS  1-cycle pulse on debounced press
//   Release   out  N_KEYS  1-cycle pulse on debounced release
// BEHAVIOUR
// - Reset (sync, high): sync flops <= 1 (released). FSM <= UP. Counter <= 0.
//   Held, Press and Release <= 0. Reset overrides all; a debounce in progress
//   is aborted with no pulse.
// - Sync: s1 <= KEY[i]; s2 <= s1. The FSM sees only s2.
// - FSM per channel (registered). c = counter, D = DEBOUNCE_CYCLES.
//   UP       : s2==0 -> CHK_DN, c<=0; else stay.
//   CHK_DN   : s2==1 -> UP (bounce, no pulse).
//              s2==0 && c==D-1 -> DOWN, Held<=1, Press<=1.
//              else c<=c+1.
//   DOWN     : s2==1 -> CHK_UP, c<=0; else stay.
//   CHK_UP   : s2==0 -> DOWN (bounce, no pulse).
//              s2==1 && c==D-1 -> UP, Held<=0, Release<=1.
//              else c<=c+1.
// - Pulse and level timing:
//   Press and Release are high for exactly one cycle; otherwise 0.
//   Press and Release are never high together on the same channel.
//   Held changes in the same cycle its pulse asserts.
// - Latency: let edge k be the first posedge where s1 samples the new level and
//   the level is stable from then on. FSM enters CHK_* at edge k+2. The
//   Held/pulse update is registered at edge k+2+D.
// - A glitch shorter than D cycles after sync produces no output change. The
//   counter restarts from 0 on every re-entry into CHK_*.
// - Counter never wraps; it is bounded by D-1. The c==D-1 compare is done at
//   CNT_W bits.
// - If a key is held through reset release, the channel starts in UP and takes
//   the full debounce path, so one Press is generated about D+2 cycles after reset.
// - Channels are fully independent; simultaneous events on several keys each
//   produce their own pulses in the same cycle.
// STRUCTURE
//   Shared package/include de_defs: FSM state encodings (UP=2'd0, CHK_DN=2'd1,
//   DOWN=2'd2, CHK_UP=2'd3) and the default debounce constant.
//   Sub-module key_debounce_ch: one channel (sync, counter, FSM, outputs),
//   instantiated N_KEYS times in a generate loop. Top level only slices buses.
// TESTING  (DEBOUNCE_CYCLES=4, N_KEYS=2)
//   1 Reset held 3 cycles with KEY=2'b00 -> Held=Press=Release=0 throughout;
//     after release, Press[1:0]=2'b11 pulse at edge 2+4 after the first edge with
//     Reset=0.
//   2 Clean press: KEY[0] 1->0, first sampled at edge k -> Press[0]=1 only after
//     edge k+6; Held[0]=1 from then on; Press[1], Release stay 0.
//   3 Bounce: KEY[0] toggles 0,1,0,1 every 2 cycles, then holds 0 -> no pulse
//     during the bounce; single Press[0] 6 edges after the final stable 0 is
//     first sampled.
//   4 Release: from Held[0]=1, KEY[0]->1 held -> Release[0] 1-cycle pulse after
//     edge k+6, Held[0]=0. A 3-cycle 1-blip instead -> no Release, Held stays 1.
//   5 Reset mid-debounce: Reset asserted 2 cycles after entering CHK_DN -> no
//     Press; outputs 0; FSM=UP next cycle.
//   6 Simultaneous: KEY 2'b11->2'b00 on the same edge -> Press=2'b11 in the same
//     cycle, then exactly one pulse each.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default sizing constants.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_CHK_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_CHK_UP = 2'd3
    } deb_state_t;

    localparam int DEFAULT_N_KEYS          = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser on the active-low key, a bounded
// stability counter and a four-state FSM producing level and edge pulses.
import key_debounce_pkg::*;

module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic press,
    output logic rel
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_r;
    logic             s2_r;
    deb_state_t       state_r;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             held_r;
    logic             held_nxt;
    logic             press_r;
    logic             press_nxt;
    logic             rel_r;
    logic             rel_nxt;

    // Synchroniser: resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= key_n;
            s2_r <= s1_r;
        end
    end

    // Next-state logic; a return to the old level while checking aborts silently.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        held_nxt  = held_r;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state_r)
            ST_UP: begin
                if (!s2_r) begin
                    state_nxt = ST_CHK_DN;
                    cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    state_nxt = ST_UP;
                end
            end
            ST_CHK_DN: begin
                if (s2_r) begin
                    state_nxt = ST_UP;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt = ST_DOWN;
                    held_nxt  = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (s2_r) begin
                    state_nxt = ST_CHK_UP;
                    cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    state_nxt = ST_DOWN;
                end
            end
            ST_CHK_UP: begin
                if (!s2_r) begin
                    state_nxt = ST_DOWN;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt = ST_UP;
                    held_nxt  = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_UP;
                cnt_nxt   = {CNT_W{1'b0}};
                held_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_UP;
            cnt_r   <= {CNT_W{1'b0}};
            held_r  <= 1'b0;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            held_r  <= held_nxt;
            press_r <= press_nxt;
            rel_r   <= rel_nxt;
        end
    end

    assign held  = held_r;
    assign press = press_r;
    assign rel   = rel_r;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton conditioning for N_KEYS active-low keys: one independent
// debounce channel per key; this level only slices the buses.
import key_debounce_pkg::*;

module key_debounce #(
    parameter int N_KEYS          = DEFAULT_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] Held,
    output logic [N_KEYS-1:0] Press,
    output logic [N_KEYS-1:0] Release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (CLOCK_50),
            .reset (Reset),
            .key_n (KEY[i]),
            .held  (Held[i]),
            .press (Press[i]),
            .rel   (Release[i])
        );
    end

endmodule
